// File: rtl/matrix_pkg.sv
// Shared definitions for the sequential matrix multiplier datapath:
// default sizes, loader state encoding, and index/offset helpers.
package matrix_pkg;

    localparam int N_DEFAULT = 32'sd3;
    localparam int M_DEFAULT = 32'sd32;

    typedef logic [1:0] state_t;

    localparam state_t LOAD_X = 2'd0;
    localparam state_t LOAD_Y = 2'd1;
    localparam state_t FULL   = 2'd2;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 32'sd0;
        rem    = value - 32'sd1;
        while (rem > 32'sd0) begin
            result = result + 32'sd1;
            rem    = rem >>> 32'sd1;
        end
        return result;
    endfunction

    // Element index width; a 1x1 matrix still needs a one-bit index.
    function automatic int idx_width(input int n);
        return (clog2(n * n) > 32'sd1) ? clog2(n * n) : 32'sd1;
    endfunction

    function automatic int elem_offset(input int m, input int idx);
        return m * idx;
    endfunction

endpackage

// File: rtl/matrix_elem_store.sv
// Flat N*N x M element register bank with a single indexed write port.
module matrix_elem_store
    import matrix_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int M  = M_DEFAULT,
    parameter int IW = idx_width(N_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [IW-1:0]      idx,
    input  logic [M-1:0]       wdata,
    output logic [M*N*N-1:0]   data
);

    logic [M*N*N-1:0] store_q;
    logic [M*N*N-1:0] store_d;

    // Write the addressed element; every other element holds its value.
    always_comb begin
        store_d = store_q;
        for (int i = 32'sd0; i < N * N; i++) begin
            if (we && (idx == IW'(i))) begin
                store_d[elem_offset(M, i) +: M] = wdata;
            end else begin
                store_d[elem_offset(M, i) +: M] = store_q[elem_offset(M, i) +: M];
            end
        end
    end

    // Bank register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_q <= '0;
        end else begin
            store_q <= store_d;
        end
    end

    assign data = store_q;

endmodule

// File: rtl/matrix_operand_loader.sv
// Streams X then Y elements into flat operand buses and holds them until released.
// Optional checksum output enabled by MATRIX_LOADER_CHECKSUM_EN.
module matrix_operand_loader
    import matrix_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int M = M_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M-1:0]     in_data,
    output logic [M*N*N-1:0] x,
    output logic [M*N*N-1:0] y,
    output logic             out_valid,
    output logic             start,
    input  logic             out_ack
`ifdef MATRIX_LOADER_CHECKSUM_EN
    ,
    output logic [M-1:0]     checksum
`endif
);

    localparam int IW = idx_width(N);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          out_valid_q, out_valid_d;
    logic          start_q, start_d;
    logic          accept_s, last_s, x_we_s, y_we_s;

    assign accept_s = in_valid && in_ready;
    assign last_s   = (idx_q == IW'(N * N - 32'sd1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD_X;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD_X: begin
                if (accept_s && last_s) state_d = LOAD_Y;
                else                    state_d = state_q;
            end
            LOAD_Y: begin
                if (accept_s && last_s) state_d = FULL;
                else                    state_d = state_q;
            end
            FULL: begin
                if (out_ack) state_d = LOAD_X;
                else         state_d = state_q;
            end
            default: state_d = LOAD_X;
        endcase
    end

    // Ready depends on state alone so upstream never sees a valid->ready loop.
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            LOAD_X:  in_ready = 1'b1;
            LOAD_Y:  in_ready = 1'b1;
            FULL:    in_ready = 1'b0;
            default: in_ready = 1'b0;
        endcase
    end

    // Index, write strobes and completion flags.
    always_comb begin
        idx_d       = idx_q;
        x_we_s      = 1'b0;
        y_we_s      = 1'b0;
        out_valid_d = out_valid_q;
        start_d     = 1'b0;
        case (state_q)
            LOAD_X: begin
                x_we_s = accept_s;
                if (accept_s) idx_d = last_s ? '0 : idx_q + IW'(1'b1);
                else          idx_d = idx_q;
            end
            LOAD_Y: begin
                y_we_s = accept_s;
                if (accept_s && last_s) begin
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    start_d     = 1'b1;
                end else if (accept_s) begin
                    idx_d = idx_q + IW'(1'b1);
                end else begin
                    idx_d = idx_q;
                end
            end
            FULL: begin
                if (out_ack) begin
                    idx_d       = '0;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                idx_d       = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            start_q     <= start_d;
        end
    end

    assign out_valid = out_valid_q;
    assign start     = start_q;

    matrix_elem_store #(.N(N), .M(M), .IW(IW)) u_x_store (
        .clk   (clk),
        .rst   (rst),
        .we    (x_we_s),
        .idx   (idx_q),
        .wdata (in_data),
        .data  (x)
    );

    matrix_elem_store #(.N(N), .M(M), .IW(IW)) u_y_store (
        .clk   (clk),
        .rst   (rst),
        .we    (y_we_s),
        .idx   (idx_q),
        .wdata (in_data),
        .data  (y)
    );

`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [M-1:0] checksum_q, checksum_d;

    // Running sum of the current load; cleared when the consumer releases.
    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == FULL) && out_ack) begin
            checksum_d = '0;
        end else if (accept_s) begin
            checksum_d = checksum_q + in_data;
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Scoreboard bench for matrix_operand_loader (N=3/M=32 and N=1/M=8 instances).
module tb_matrix_operand_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main instance, N=3 M=32
    logic          in_valid, in_ready, out_valid, start, out_ack;
    logic [31:0]   in_data;
    logic [287:0]  x, y;
    // Corner instance, N=1 M=8
    logic          s_in_valid, s_in_ready, s_out_valid, s_start, s_out_ack;
    logic [7:0]    s_in_data, s_x, s_y;
`ifdef MATRIX_LOADER_CHECKSUM_EN
    logic [31:0]   checksum;
    logic [7:0]    s_checksum;
`endif

    matrix_operand_loader #(.N(3), .M(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .x(x), .y(y), .out_valid(out_valid),
        .start(start), .out_ack(out_ack)
`ifdef MATRIX_LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    matrix_operand_loader #(.N(1), .M(8)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .x(s_x), .y(s_y), .out_valid(s_out_valid),
        .start(s_start), .out_ack(s_out_ack)
`ifdef MATRIX_LOADER_CHECKSUM_EN
        , .checksum(s_checksum)
`endif
    );

    typedef struct {
        logic [287:0] x;
        logic [287:0] y;
        logic [31:0]  cks;
    } exp_t;

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] cks;
    } exp_s_t;

    exp_t   q_main[$];
    exp_s_t q_small[$];
    exp_t   last_exp;
    exp_t   mon_e;
    exp_s_t mon_s;
    logic   start_prev;
    logic   s_start_prev;
    logic [31:0] dx[18];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares completed buffers against the scoreboard on every start pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (start_prev === 1'b1) chk("start_width", {287'd0, start}, 288'd0);
            if (start === 1'b1) begin
                if (q_main.size() == 0) begin
                    chk("unexpected_start", 288'd1, 288'd0);
                end else begin
                    mon_e = q_main.pop_front();
                    chk("mon_x", x, mon_e.x);
                    chk("mon_y", y, mon_e.y);
                    chk("mon_out_valid", {287'd0, out_valid}, 288'd1);
`ifdef MATRIX_LOADER_CHECKSUM_EN
                    chk("mon_checksum", {256'd0, checksum}, {256'd0, mon_e.cks});
`endif
                end
            end
            if (s_start_prev === 1'b1) chk("s_start_width", {287'd0, s_start}, 288'd0);
            if (s_start === 1'b1) begin
                if (q_small.size() == 0) begin
                    chk("s_unexpected_start", 288'd1, 288'd0);
                end else begin
                    mon_s = q_small.pop_front();
                    chk("s_mon_x", {280'd0, s_x}, {280'd0, mon_s.x});
                    chk("s_mon_y", {280'd0, s_y}, {280'd0, mon_s.y});
                    chk("s_mon_out_valid", {287'd0, s_out_valid}, 288'd1);
`ifdef MATRIX_LOADER_CHECKSUM_EN
                    chk("s_mon_checksum", {280'd0, s_checksum}, {280'd0, mon_s.cks});
`endif
                end
            end
        end
        start_prev   <= start;
        s_start_prev <= s_start;
    end

    // Offer one beat (after optional idle cycles) and return on the negedge after it is taken.
    task automatic send(input logic [31:0] d, input int gap);
        int w;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = d;
        w = 0;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) chk("send_timeout", 288'd1, 288'd0);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 32'h0BAD0BAD;
    endtask

    task automatic load_main(input bit gaps, input bit acks);
        exp_t e;
        e.x = '0;
        e.y = '0;
        e.cks = 32'd0;
        for (int i = 0; i < 9; i++) begin
            e.x[i*32 +: 32] = dx[i];
            e.y[i*32 +: 32] = dx[9+i];
        end
        for (int i = 0; i < 18; i++) e.cks = e.cks + dx[i];
        q_main.push_back(e);
        last_exp = e;
        for (int i = 0; i < 18; i++) begin
            out_ack = acks && (i == 3 || i == 12);
            send(dx[i], gaps ? ((i % 3 == 1) ? 1 : ((i % 4 == 2) ? 2 : 0)) : 0);
            out_ack = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = 32'd0; out_ack = 1'b0;
        s_in_valid = 1'b0; s_in_data = 8'd0; s_out_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {287'd0, out_valid}, 288'd0);
        chk("rst_start", {287'd0, start}, 288'd0);
        chk("rst_x", x, 288'd0);
        chk("rst_y", y, 288'd0);
        chk("rst_in_ready", {287'd0, in_ready}, 288'd1);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back load X=1..9, Y=10..18
        for (int i = 0; i < 18; i++) dx[i] = 32'(i + 1);
        load_main(1'b0, 1'b0);
        chk("x00", {256'd0, x[0 +: 32]}, 288'd1);
        chk("x22", {256'd0, x[8*32 +: 32]}, 288'd9);
        chk("y12", {256'd0, y[5*32 +: 32]}, 288'd15);
        chk("full_out_valid", {287'd0, out_valid}, 288'd1);
        chk("full_in_ready", {287'd0, in_ready}, 288'd0);

        // Offered beats while FULL must not disturb the buffers
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        repeat (20) @(negedge clk);
        chk("hold_x", x, last_exp.x);
        chk("hold_y", y, last_exp.y);
        chk("hold_out_valid", {287'd0, out_valid}, 288'd1);
        in_valid = 1'b0;

        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk("rel_out_valid", {287'd0, out_valid}, 288'd0);
        chk("rel_in_ready", {287'd0, in_ready}, 288'd1);

        // Same data with idle gaps
        load_main(1'b1, 1'b0);
        chk("gap_out_valid", {287'd0, out_valid}, 288'd1);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;

        // First beat after release lands in x(0,0); older elements persist
        send(32'h00000055, 0);
        chk("reload_x00", {256'd0, x[0 +: 32]}, 288'h55);
        chk("reload_x01_kept", {256'd0, x[32 +: 32]}, 288'd2);
        for (int i = 0; i < 4; i++) send(32'h100 + 32'(i), 0);

        // Asynchronous reset mid-load
        rst = 1'b1;
        #1;
        chk("arst_out_valid", {287'd0, out_valid}, 288'd0);
        chk("arst_x", x, 288'd0);
        chk("arst_y", y, 288'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // All-ones load with out_ack pulses during LOAD_X/LOAD_Y
        for (int i = 0; i < 18; i++) dx[i] = 32'hFFFFFFFF;
        load_main(1'b0, 1'b1);
        chk("ones_cks_model", {256'd0, last_exp.cks}, 288'hFFFFFFEE);
        // out_ack on the start cycle
        chk("ackstart_start", {287'd0, start}, 288'd1);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk("ackstart_out_valid", {287'd0, out_valid}, 288'd0);
        chk("ackstart_in_ready", {287'd0, in_ready}, 288'd1);
        chk("ackstart_x_kept", x, {288{1'b1}});

        // N=1, M=8 corner
        q_small.push_back('{x: 8'h03, y: 8'h05, cks: 8'h08});
        s_in_valid = 1'b1;
        s_in_data  = 8'h03;
        @(negedge clk);
        s_in_data  = 8'h05;
        @(negedge clk);
        s_in_valid = 1'b0;
        chk("s_out_valid", {287'd0, s_out_valid}, 288'd1);
        chk("s_in_ready", {287'd0, s_in_ready}, 288'd0);
        chk("s_x", {280'd0, s_x}, 288'h03);
        chk("s_y", {280'd0, s_y}, 288'h05);

        repeat (3) @(negedge clk);
        chk("q_main_drained", 288'(q_main.size()), 288'd0);
        chk("q_small_drained", 288'(q_small.size()), 288'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
